// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with data-cache miss stall control and statistics
module ex_mem_stage #(
  parameter int pc_size   = 18,
  parameter int data_size = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 EX_MemtoReg,
  input  logic                 EX_RegWrite,
  input  logic                 EX_MemWrite,
  input  logic                 EX_Read_enable,
  input  logic                 EX_SH,
  input  logic                 EX_LH,
  input  logic                 EX_to_reg31,
  input  logic [data_size-1:0] EX_ALU_result,
  input  logic [data_size-1:0] EX_Rt_data,
  input  logic [4:0]           EX_WR_out,
  input  logic [pc_size-1:0]   EX_PC,
  input  logic                 Mem_ready,
  input  logic                 stat_clr,
  output logic                 M_MemtoReg,
  output logic                 M_RegWrite,
  output logic                 M_MemWrite,
  output logic                 M_Read_enable,
  output logic                 M_SH,
  output logic                 M_LH,
  output logic                 M_to_reg31,
  output logic [data_size-1:0] M_ALU_result,
  output logic [data_size-1:0] M_Write_data,
  output logic [4:0]           M_WR_out,
  output logic [pc_size-1:0]   M_PC,
  output logic                 Stall,
  output logic                 M_fwd_valid,
  output logic [data_size-1:0] M_fwd_data,
  output logic [15:0]          miss_count,
  output logic [15:0]          stall_cycles
);

  typedef enum logic {ST_RUN = 1'b0, ST_MISS = 1'b1} state_t;

  state_t r_state;
  state_t w_state_next;
  logic   w_miss_start;

  logic                 r_memtoreg;
  logic                 r_regwrite;
  logic                 r_memwrite;
  logic                 r_read_enable;
  logic                 r_sh;
  logic                 r_lh;
  logic                 r_to_reg31;
  logic [data_size-1:0] r_alu_result;
  logic [data_size-1:0] r_write_data;
  logic [4:0]           r_wr_out;
  logic [pc_size-1:0]   r_pc;
  logic [15:0]          r_miss_count;
  logic [15:0]          r_stall_cycles;

  logic                 w_acc;
  logic                 w_stall;
  logic [data_size-1:0] w_store_data;

  // Stall depends only on the held MEM-stage instruction and the cache handshake
  always_comb begin
    w_acc   = r_read_enable | r_memwrite;
    w_stall = w_acc & ~Mem_ready;
  end

  // Halfword stores replicate the low half so either byte lane pair carries the data
  always_comb begin
    w_store_data = EX_SH ? {EX_Rt_data[15:0], EX_Rt_data[15:0]} : EX_Rt_data;
  end

  // Miss tracker state register; async reset aborts any miss in progress
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) r_state <= ST_RUN;
    else      r_state <= w_state_next;
  end

  // Miss tracker next state; a miss is counted only on entry from RUN
  always_comb begin
    w_state_next = r_state;
    w_miss_start = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_stall) begin
          w_state_next = ST_MISS;
          w_miss_start = 1'b1;
        end
      end
      ST_MISS: begin
        if (!w_stall) w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  // Pipeline register: hold while stalled, otherwise capture the EX instruction
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_memtoreg    <= 1'b0;
      r_regwrite    <= 1'b0;
      r_memwrite    <= 1'b0;
      r_read_enable <= 1'b0;
      r_sh          <= 1'b0;
      r_lh          <= 1'b0;
      r_to_reg31    <= 1'b0;
      r_alu_result  <= '0;
      r_write_data  <= '0;
      r_wr_out      <= '0;
      r_pc          <= '0;
    end else if (!w_stall) begin
      r_memtoreg    <= EX_MemtoReg;
      r_regwrite    <= EX_RegWrite;
      r_memwrite    <= EX_MemWrite;
      r_read_enable <= EX_Read_enable;
      r_sh          <= EX_SH;
      r_lh          <= EX_LH;
      r_to_reg31    <= EX_to_reg31;
      r_alu_result  <= EX_ALU_result;
      r_write_data  <= w_store_data;
      r_wr_out      <= EX_WR_out;
      r_pc          <= EX_PC;
    end
  end

  // Saturating statistics; clear beats any increment on the same edge
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_miss_count   <= '0;
      r_stall_cycles <= '0;
    end else if (stat_clr) begin
      r_miss_count   <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (w_miss_start && (r_miss_count != 16'hFFFF)) r_miss_count <= r_miss_count + 16'd1;
      if (w_stall && (r_stall_cycles != 16'hFFFF))    r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign M_MemtoReg    = r_memtoreg;
  assign M_RegWrite    = r_regwrite;
  assign M_MemWrite    = r_memwrite;
  assign M_Read_enable = r_read_enable;
  assign M_SH          = r_sh;
  assign M_LH          = r_lh;
  assign M_to_reg31    = r_to_reg31;
  assign M_ALU_result  = r_alu_result;
  assign M_Write_data  = r_write_data;
  assign M_WR_out      = r_wr_out;
  assign M_PC          = r_pc;
  assign Stall         = w_stall;
  assign miss_count    = r_miss_count;
  assign stall_cycles  = r_stall_cycles;

  // Loads resolve in MEM, so only non-load register writes forward from here
  assign M_fwd_valid = r_regwrite & ~r_memtoreg & (r_wr_out != 5'd0);
  assign M_fwd_data  = r_to_reg31 ? {{(data_size-pc_size){1'b0}}, r_pc} : r_alu_result;

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX/MEM pipeline register plus data-cache miss stall controller, directly downstream of the ID/EX register and feeding the MEM-stage cache and the MEM/WB register. Latches EX-stage control and data on the falling edge of `clk`. Holds its contents and raises a pipeline-wide stall while a cache access in MEM is not ready. Keeps saturating miss/stall statistics.

## Interface
- `pc_size`, 18: PC width.
- `data_size`, 32: datapath width.
- `clk` in 1: pipeline clock; all state updates on the falling edge.
- `rst` in 1: asynchronous, active-low reset.
- `EX_MemtoReg`, `EX_RegWrite`, `EX_MemWrite`, `EX_Read_enable` in 1 each: control from EX.
- `EX_SH`, `EX_LH`, `EX_to_reg31` in 1 each: halfword store, halfword load, link-to-$31 from EX.
- `EX_ALU_result` in `data_size`: address / ALU result.
- `EX_Rt_data` in `data_size`: store data after forwarding.
- `EX_WR_out` in 5: destination register.
- `EX_PC` in `pc_size`: PC of the EX instruction.
- `Mem_ready` in 1: cache has completed the current MEM access this cycle.
- `stat_clr` in 1: synchronous clear of statistics counters.
- `M_MemtoReg`, `M_RegWrite`, `M_MemWrite`, `M_Read_enable`, `M_SH`, `M_LH`, `M_to_reg31` out 1 each: registered control.
- `M_ALU_result` out `data_size`: registered address/result.
- `M_Write_data` out `data_size`: aligned store data.
- `M_WR_out` out 5; `M_PC` out `pc_size`.
- `Stall` out 1: hold request to PC, IF/ID, ID/EX, and MEM/WB writes.
- `M_fwd_valid` out 1; `M_fwd_data` out `data_size`: EX-forwarding source.
- `miss_count` out 16; `stall_cycles` out 16: statistics.

## Operation
- Memory access in MEM is `acc = M_Read_enable | M_MemWrite`.
- `Stall = acc & ~Mem_ready`. This is combinational and depends on no state other than the M registers.
- FSM with two states, RUN and MISS:
  - RUN -> MISS at an edge where `Stall=1`; `miss_count` increments on that edge.
  - MISS -> MISS while `Stall=1`.
  - MISS -> RUN at the first edge with `Mem_ready=1`.
  - `stall_cycles` increments on every edge where `Stall=1`, in either state.
- Register update at each falling edge:
  - `Stall=1`: all M outputs hold their values.
  - `Stall=0`: all M outputs load from the EX inputs.
- Hold wins over any new EX data. The stage has no flush input; bubbles arrive from ID/EX as zeroed control.
- `M_Write_data` is registered:
  - `{EX_Rt_data[15:0], EX_Rt_data[15:0]}` when `EX_SH=1`.
  - `EX_Rt_data` otherwise.
- `M_fwd_valid = M_RegWrite & ~M_MemtoReg & (M_WR_out != 0)`. Loads never forward from MEM.
- `M_fwd_data = M_to_reg31 ? {{(data_size-pc_size){1'b0}}, M_PC} : M_ALU_result`.
- Counters:
  - Both are 16-bit and saturate at 0xFFFF; no wrap.
  - `stat_clr=1` zeroes both at the edge and takes priority over an increment in the same cycle.
- Reset (`rst=0`):
  - All M registers are 0 and both counters are 0.
  - FSM is in RUN; `Stall`, `M_fwd_valid` and `M_fwd_data` are therefore 0.
  - Reset asserted during MISS aborts the miss immediately. `Stall` falls in the same cycle, with no completion edge required.

## Timing
- Latency of one falling edge from EX inputs to M outputs when not stalled.
- `Stall` is valid in the same cycle as `M_*` and `Mem_ready`. Upstream registers must sample it at the same falling edge.
- A hit (`Mem_ready=1` in the first cycle) costs 0 stall cycles and leaves `miss_count` unchanged.
- A miss with N not-ready cycles costs exactly N stall cycles: `stall_cycles += N`, `miss_count += 1`.
- Back-to-back accesses: a second access entering on the release edge is evaluated fresh in RUN.
- `Mem_ready` asserted while `acc=0` is ignored.
- Reset release: the first falling edge with `rst=1` loads EX inputs normally.

## Test plan
- Reset then ALU op with `EX_RegWrite=1`, `EX_ALU_result=0x1234`, `EX_WR_out=5`:
  - After one edge, `M_fwd_valid=1` and `M_fwd_data=0x1234`.
  - `Stall=0`.
- Load with `Mem_ready=0` for 3 cycles, then 1:
  - `Stall=1` for 3 cycles.
  - M outputs unchanged throughout while EX inputs change.
  - `miss_count=1`, `stall_cycles=3`; the next EX word is loaded on the release edge.
- SH with `EX_Rt_data=0xAABBCCDD`:
  - `M_Write_data=0xCCDDCCDD`, `M_SH=1`.
  - With `Mem_ready=1`: no stall and `miss_count` stays 0.
- JAL-style `EX_to_reg31=1`, `EX_PC=0x00040`, `EX_WR_out=31`:
  - `M_fwd_data=0x00000040`.
  - Load with `M_WR_out=0`, or with `MemtoReg=1`: `M_fwd_valid=0`.
- Preload `stall_cycles=0xFFFE`, then a 4-cycle miss:
  - Ends at 0xFFFF.
  - Then `stat_clr=1` during a stall edge: both counters read 0.
- Assert `rst=0` in the second cycle of a miss:
  - `Stall`, all M outputs and both counters are 0 immediately.
  - After release, a hit proceeds with no stall.
